pio_apb_bridge: RTL and testbench



---
 rtl/pio_apb_bridge.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_pio_apb_bridge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_apb_bridge.sv
// rtl/pio_apb_bridge.sv - APB3 slave translating RP2040-style PIO register accesses into pio command strobes
module pio_apb_bridge #(
    parameter int unsigned NUM_MACHINES = 4,
    parameter logic [31:0] VERSION      = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [8:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [3:0]  action,
    output logic [1:0]  mindex,
    output logic [4:0]  index,
    output logic [31:0] din,
    input  logic [31:0] pio_dout,
    input  logic [3:0]  tx_empty,
    input  logic [3:0]  tx_full,
    input  logic [3:0]  rx_empty,
    input  logic [3:0]  rx_full,
    input  logic [2:0]  tx_level0,
    input  logic [2:0]  tx_level1,
    input  logic [2:0]  tx_level2,
    input  logic [2:0]  tx_level3,
    input  logic [2:0]  rx_level0,
    input  logic [2:0]  rx_level1,
    input  logic [2:0]  rx_level2,
    input  logic [2:0]  rx_level3
);

    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_PULL  = 4'd3;
    localparam logic [3:0] ACT_PUSH  = 4'd4;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_IMM   = 4'd9;
    localparam logic [3:0] ACT_SHIFT = 4'd10;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [3:0]  action_q, action_d;
    logic [1:0]  mindex_q, mindex_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] din_q, din_d;

    logic [3:0]  ctrl_q;
    logic [31:0] clkdiv_q    [NUM_MACHINES];
    logic [31:0] execctrl_q  [NUM_MACHINES];
    logic [31:0] shiftctrl_q [NUM_MACHINES];
    logic [31:0] pinctrl_q   [NUM_MACHINES];

    logic [6:0]  waddr;
    logic        unused_bits;
    logic        sm_hit;
    logic [1:0]  sm_sel;
    logic [2:0]  sm_reg;
    logic        dec_err;
    logic [3:0]  dec_act;
    logic [1:0]  dec_mindex;
    logic [4:0]  dec_index;
    logic [31:0] dec_din;
    logic [31:0] dec_rdata;
    logic        sel_ctrl, sel_clkdiv, sel_exec, sel_shift, sel_pin;
    logic        issue_wr;

    assign waddr       = paddr[8:2];
    assign unused_bits = ^paddr[1:0];

    // Decode is purely combinational on the live bus and flags; only the IDLE cycle acts on it.
    always_comb begin
        sm_hit     = 1'b0;
        sm_sel     = '0;
        sm_reg     = '0;
        dec_err    = 1'b0;
        dec_act    = ACT_NONE;
        dec_mindex = '0;
        dec_index  = '0;
        dec_din    = '0;
        dec_rdata  = '0;
        sel_ctrl   = 1'b0;
        sel_clkdiv = 1'b0;
        sel_exec   = 1'b0;
        sel_shift  = 1'b0;
        sel_pin    = 1'b0;
        for (int n = 0; n < NUM_MACHINES; n++) begin
            if (waddr >= 7'(50 + 6 * n) && waddr < 7'(56 + 6 * n)) begin
                sm_hit = 1'b1;
                sm_sel = 2'(n);
                sm_reg = 3'(waddr - 7'(50 + 6 * n));
            end
        end
        if (waddr == 7'd0) begin
            if (pwrite) begin
                dec_act  = ACT_EN;
                dec_din  = {20'b0, pwdata[11:0]};
                sel_ctrl = 1'b1;
            end else begin
                dec_rdata = {28'b0, ctrl_q};
            end
        end else if (waddr == 7'd1) begin
            dec_err   = pwrite;
            dec_rdata = {4'b0, tx_empty, 4'b0, tx_full, 4'b0, rx_empty, 4'b0, rx_full};
        end else if (waddr == 7'd3) begin
            dec_err   = pwrite;
            dec_rdata = {1'b0, rx_level3, 1'b0, tx_level3, 1'b0, rx_level2, 1'b0, tx_level2,
                         1'b0, rx_level1, 1'b0, tx_level1, 1'b0, rx_level0, 1'b0, tx_level0};
        end else if (waddr[6:2] == 5'b00001) begin
            if (!pwrite || tx_full[waddr[1:0]]) begin
                dec_err = 1'b1;
            end else begin
                dec_act    = ACT_PUSH;
                dec_mindex = waddr[1:0];
                dec_din    = pwdata;
            end
        end else if (waddr[6:2] == 5'b00010) begin
            if (pwrite || rx_empty[waddr[1:0]]) begin
                dec_err = 1'b1;
            end else begin
                dec_act    = ACT_PULL;
                dec_mindex = waddr[1:0];
            end
        end else if (waddr >= 7'd18 && waddr <= 7'd49) begin
            if (!pwrite) begin
                dec_err = 1'b1;
            end else begin
                dec_act   = ACT_INSTR;
                dec_index = 5'(waddr - 7'd18);
                dec_din   = {16'b0, pwdata[15:0]};
            end
        end else if (sm_hit) begin
            dec_mindex = sm_sel;
            case (sm_reg)
                3'd0: begin
                    dec_act    = pwrite ? ACT_DIV : ACT_NONE;
                    dec_din    = {8'b0, pwdata[31:8]};
                    dec_rdata  = clkdiv_q[sm_sel];
                    sel_clkdiv = pwrite;
                end
                3'd1: begin
                    dec_act   = pwrite ? ACT_PEND : ACT_NONE;
                    dec_din   = pwdata;
                    dec_rdata = execctrl_q[sm_sel];
                    sel_exec  = pwrite;
                end
                3'd2: begin
                    dec_act   = pwrite ? ACT_SHIFT : ACT_NONE;
                    dec_din   = pwdata;
                    dec_rdata = shiftctrl_q[sm_sel];
                    sel_shift = pwrite;
                end
                3'd3: dec_err = pwrite;
                3'd4: begin
                    dec_err = !pwrite;
                    dec_act = pwrite ? ACT_IMM : ACT_NONE;
                    dec_din = {16'b0, pwdata[15:0]};
                end
                3'd5: begin
                    dec_act   = pwrite ? ACT_GRPS : ACT_NONE;
                    dec_din   = pwdata;
                    dec_rdata = pinctrl_q[sm_sel];
                    sel_pin   = pwrite;
                end
                default: dec_err = 1'b1;
            endcase
        end else if (waddr == 7'd82) begin
            dec_err   = pwrite;
            dec_rdata = VERSION;
        end else begin
            dec_err = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        action_d  = ACT_NONE;
        mindex_d  = mindex_q;
        index_d   = index_q;
        din_d     = din_q;
        issue_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && penable) begin
                    if (dec_err) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else if (dec_act != ACT_NONE) begin
                        state_d  = ISSUE;
                        action_d = dec_act;
                        mindex_d = dec_mindex;
                        index_d  = dec_index;
                        din_d    = dec_din;
                        prdata_d = '0;
                        pready_d = pwrite;
                        issue_wr = pwrite;
                    end else begin
                        state_d  = RESP;
                        pready_d = 1'b1;
                        prdata_d = dec_rdata;
                    end
                end
            end
            ISSUE: begin
                state_d = (action_q == ACT_PULL) ? CAPTURE : IDLE;
            end
            // pio presents the popped word exactly one cycle after PULL.
            CAPTURE: begin
                state_d  = RESP;
                prdata_d = pio_dout;
                pready_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            action_q  <= ACT_NONE;
            mindex_q  <= '0;
            index_q   <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            action_q  <= action_d;
            mindex_q  <= mindex_d;
            index_q   <= index_d;
            din_q     <= din_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
            for (int n = 0; n < NUM_MACHINES; n++) begin
                clkdiv_q[n]    <= 32'h0001_0000;
                execctrl_q[n]  <= '0;
                shiftctrl_q[n] <= '0;
                pinctrl_q[n]   <= '0;
            end
        end else if (issue_wr) begin
            if (sel_ctrl)   ctrl_q              <= pwdata[3:0];
            if (sel_clkdiv) clkdiv_q[sm_sel]    <= {pwdata[31:8], 8'h00};
            if (sel_exec)   execctrl_q[sm_sel]  <= pwdata;
            if (sel_shift)  shiftctrl_q[sm_sel] <= pwdata;
            if (sel_pin)    pinctrl_q[sm_sel]   <= pwdata;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign action  = action_q;
    assign mindex  = mindex_q;
    assign index   = index_q;
    assign din     = din_q;

endmodule

// File: tb/tb_pio_apb_bridge.sv
// tb/tb_pio_apb_bridge.sv - randomized self-checking bench for pio_apb_bridge against a register-map model
module tb_pio_apb_bridge;

    localparam logic [31:0] VSTUB = 32'hC0DE_0001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [8:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic [4:0]  index;
    logic [31:0] din;
    logic [31:0] pio_dout = VSTUB;
    logic [3:0]  tx_empty = '0, tx_full = '0, rx_empty = '0, rx_full = '0;
    logic [2:0]  txl [4];
    logic [2:0]  rxl [4];

    int total = 0;
    int bad   = 0;

    logic [3:0]  m_ctrl;
    logic [31:0] m_clk [4], m_exec [4], m_shift [4], m_pin [4];

    always #5 clk = ~clk;

    pio_apb_bridge dut (
        .clk(clk), .reset_n(reset_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .action(action), .mindex(mindex), .index(index), .din(din),
        .pio_dout(pio_dout),
        .tx_empty(tx_empty), .tx_full(tx_full), .rx_empty(rx_empty), .rx_full(rx_full),
        .tx_level0(txl[0]), .tx_level1(txl[1]), .tx_level2(txl[2]), .tx_level3(txl[3]),
        .rx_level0(rxl[0]), .rx_level1(rxl[1]), .rx_level2(rxl[2]), .rx_level3(rxl[3])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0;
        for (int n = 0; n < 4; n++) begin
            m_clk[n]   = 32'h0001_0000;
            m_exec[n]  = '0;
            m_shift[n] = '0;
            m_pin[n]   = '0;
        end
    endtask

    task automatic flags_rand();
        tx_empty = 4'($urandom);
        tx_full  = 4'($urandom);
        rx_empty = 4'($urandom);
        rx_full  = 4'($urandom);
        for (int n = 0; n < 4; n++) begin
            txl[n] = 3'($urandom);
            rxl[n] = 3'($urandom);
        end
    endtask

    // Register-map semantics computed from byte offsets; shadow effects applied on good writes.
    task automatic model(input logic [8:0] a, input logic w, input logic [31:0] d, input logic [31:0] stub,
                         output logic e, output logic [3:0] act, output logic [1:0] mi,
                         output logic [4:0] ix, output logic [31:0] dn, output logic [31:0] rd,
                         output logic cr);
        int off, n, r;
        off = int'({a[8:2], 2'b00});
        e = 1'b0; act = 4'd0; mi = '0; ix = '0; dn = '0; rd = '0;
        cr = !w;
        if (off == 0) begin
            if (w) begin act = 4'd6; dn = d & 32'hFFF; m_ctrl = d[3:0]; end
            else rd = {28'b0, m_ctrl};
        end else if (off == 4) begin
            if (w) e = 1'b1;
            else rd = {4'b0, tx_empty, 4'b0, tx_full, 4'b0, rx_empty, 4'b0, rx_full};
        end else if (off == 12) begin
            if (w) e = 1'b1;
            else for (int k = 0; k < 4; k++) rd = rd | ((32'(rxl[k]) * 16 + 32'(txl[k])) << (8 * k));
        end else if (off >= 16 && off < 32) begin
            n = (off - 16) / 4;
            if (!w || tx_full[n]) e = 1'b1;
            else begin act = 4'd4; mi = 2'(n); dn = d; end
        end else if (off >= 32 && off < 48) begin
            n = (off - 32) / 4;
            if (w) e = 1'b1;
            else if (rx_empty[n]) begin e = 1'b1; rd = '0; end
            else begin act = 4'd3; mi = 2'(n); rd = stub; end
        end else if (off >= 'h48 && off < 'hC8) begin
            if (!w) e = 1'b1;
            else begin act = 4'd1; ix = 5'((off - 'h48) / 4); dn = d & 32'hFFFF; end
        end else if (off >= 'hC8 && off < 'h128) begin
            n = (off - 'hC8) / 24;
            r = (off - 'hC8) % 24;
            mi = 2'(n);
            case (r)
                0:  if (w) begin act = 4'd7;  dn = d >> 8; m_clk[n] = d & 32'hFFFF_FF00; end else rd = m_clk[n];
                4:  if (w) begin act = 4'd2;  dn = d; m_exec[n] = d;  end else rd = m_exec[n];
                8:  if (w) begin act = 4'd10; dn = d; m_shift[n] = d; end else rd = m_shift[n];
                12: if (w) e = 1'b1; else rd = '0;
                16: if (w) begin act = 4'd9; dn = d & 32'hFFFF; end else e = 1'b1;
                default: if (w) begin act = 4'd5; dn = d; m_pin[n] = d; end else rd = m_pin[n];
            endcase
        end else if (off == 'h148) begin
            if (w) e = 1'b1; else rd = 32'h0100_0000;
        end else begin
            e = 1'b1;
        end
        if (e && !(off >= 32 && off < 48 && !w)) cr = 1'b0;
    endtask

    task automatic xfer(input logic [8:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] stub, input logic shuffle);
        logic e, cr, done, pull_seen, oerr;
        logic [3:0]  ea, oa;
        logic [1:0]  em, om;
        logic [4:0]  ei, oi;
        logic [31:0] ed, er, od, ord;
        int cyc, nact;
        model(a, w, d, stub, e, ea, em, ei, ed, er, cr);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; nact = 0; done = 1'b0; oerr = 1'b0;
        oa = '0; om = '0; oi = '0; od = '0; ord = '0;
        while (!done && cyc < 12) begin
            cyc++;
            if (action != 4'd0) begin nact++; oa = action; om = mindex; oi = index; od = din; end
            if (pready) begin done = 1'b1; ord = prdata; oerr = pslverr; end
            pull_seen = (action == 4'd3);
            @(posedge clk); #1;
            pio_dout = pull_seen ? stub : VSTUB;
            if (shuffle && cyc == 1) flags_rand();
        end
        psel = 1'b0; penable = 1'b0;
        chk("latency", 32'(cyc), (ea == 4'd3) ? 32'd4 : 32'd2);
        chk("pslverr", {31'b0, oerr}, {31'b0, e});
        chk("n_action", 32'(nact), (ea != 4'd0) ? 32'd1 : 32'd0);
        if (ea != 4'd0) begin
            chk("action", {28'b0, oa}, {28'b0, ea});
            if (ea != 4'd1 && ea != 4'd6) chk("mindex", {30'b0, om}, {30'b0, em});
            if (ea == 4'd1) chk("index", {27'b0, oi}, {27'b0, ei});
            if (ea != 4'd3) chk("din", od, ed);
        end
        if (cr) chk("prdata", ord, er);
        chk("action_after", {28'b0, action}, 32'd0);
        chk("pready_after", {31'b0, pready}, 32'd0);
    endtask

    initial begin
        logic [8:0]  a;
        logic [31:0] d;
        for (int n = 0; n < 4; n++) begin txl[n] = '0; rxl[n] = '0; end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prdata",  prdata, 32'd0);
        chk("rst_pready",  {31'b0, pready}, 32'd0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
        chk("rst_action",  {28'b0, action}, 32'd0);
        chk("rst_mindex",  {30'b0, mindex}, 32'd0);
        chk("rst_index",   {27'b0, index}, 32'd0);
        chk("rst_din",     din, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        xfer(9'h0C8, 1'b0, 32'h0, 32'h0, 1'b0);
        xfer(9'h0E0, 1'b1, 32'h0001_8000, 32'h0, 1'b0);
        xfer(9'h0E0, 1'b0, 32'h0, 32'h0, 1'b0);
        xfer(9'h05C, 1'b1, 32'h0000_E081, 32'h0, 1'b0);
        tx_full = 4'b0000;
        xfer(9'h018, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tx_full = 4'b0100;
        xfer(9'h018, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        rx_empty = 4'b0000;
        xfer(9'h02C, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
        rx_empty = 4'b1000;
        xfer(9'h02C, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
        xfer(9'h000, 1'b1, 32'h0000_00F5, 32'h0, 1'b0);
        xfer(9'h000, 1'b0, 32'h0, 32'h0, 1'b0);
        xfer(9'h150, 1'b0, 32'h0, 32'h0, 1'b0);
        xfer(9'h150, 1'b1, 32'h1, 32'h0, 1'b0);
        xfer(9'h148, 1'b0, 32'h0, 32'h0, 1'b0);
        xfer(9'h0C8, 1'b1, 32'hABCD_EF12, 32'h0, 1'b0);

        tx_full = 4'b0000;
        psel = 1'b1; penable = 1'b0; paddr = 9'h010; pwrite = 1'b1; pwdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("rst_issue_action", {28'b0, action}, 32'd4);
        reset_n = 1'b0;
        #1;
        chk("rst_async_action", {28'b0, action}, 32'd0);
        chk("rst_async_pready", {31'b0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        xfer(9'h000, 1'b0, 32'h0, 32'h0, 1'b0);
        xfer(9'h0C8, 1'b0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            flags_rand();
            if ($urandom_range(0, 1) == 0) a = 9'(9'h0C8 + 4 * $urandom_range(0, 23));
            else if ($urandom_range(0, 2) == 0) a = 9'(4 * $urandom_range(0, 11));
            else a = 9'($urandom);
            a[1:0] = 2'($urandom);
            d = $urandom;
            xfer(a, 1'($urandom), d, $urandom, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
